// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
//   Bundles every bus signal of the single-port SRAM arbiter: the IF-stage
//   fetch port, the MEM-stage load/store port, the asynchronous SRAM pins, the
//   pipeline stall request and a debug view of the arbiter FSM state.
//
// Handshake (both request ports):
//   req is a level held by the requester for as long as it wants service.
//   The arbiter grants only from IDLE and answers with ready, a pulse exactly
//   one cycle wide; rdata is valid in that ready cycle and holds until the
//   same port's next read completes. Dropping req after the grant cycle does
//   not cancel anything: the access runs to completion and ready still pulses.
//
// Modports:
//   slave  - the arbiter (ram_arbiter)
//   master - the pipeline and SRAM device side (testbench / SoC wrapper)
//
// Signals:
//   if_req, if_addr[31:0]              IF fetch request and byte address
//   if_rdata[31:0], if_ready           fetched word and completion pulse
//   mem_req, mem_we, mem_be[3:0]       MEM request, write flag, byte enables
//   mem_addr[31:0], mem_wdata[31:0]    MEM byte address and store data
//   mem_rdata[31:0], mem_ready         load data and completion pulse
//   sram_addr[19:0], sram_wdata[31:0]  SRAM word address and write data
//   sram_rdata[31:0]                   SRAM read data
//   sram_drive                         data-bus drive enable (write cycles)
//   sram_ce_n/oe_n/we_n, sram_be_n[3:0] active-low SRAM strobes
//   stall_req                          pipeline stall request
//   dbg_state[2:0]                     current arbiter FSM state
// -----------------------------------------------------------------------------
interface ram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_drive;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  logic        stall_req;
  logic [2:0]  dbg_state;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    output sram_addr, sram_wdata, sram_drive, sram_ce_n, sram_oe_n,
    output sram_we_n, sram_be_n,
    input  sram_rdata,
    output stall_req, dbg_state
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    input  sram_addr, sram_wdata, sram_drive, sram_ce_n, sram_oe_n,
    input  sram_we_n, sram_be_n,
    output sram_rdata,
    input  stall_req, dbg_state
  );
endinterface

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//   Shares one asynchronous 32-bit SRAM between the IF (fetch) and MEM
//   (load/store) pipeline stages. Arbitration happens only in IDLE and MEM
//   wins ties because it carries the older instruction.
//
//   Read  : IDLE -> RD1 -> RD2 -> DONE          (ready 3 cycles after request)
//   Write : IDLE -> WR1 -> WR2 -> WR3 -> DONE   (ready 4 cycles after request)
//   DONE always returns to IDLE and ignores requests, so a req held high
//   through its ready pulse is not granted twice back to back.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ram_arbiter_if.slave (request ports, SRAM pins, stall, debug state)
//
// All SRAM pins are registered and computed from the next state, so they
// switch cleanly on the clock edge that enters each phase.
// -----------------------------------------------------------------------------
module ram_arbiter (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_WR2  = 3'd4;
  localparam logic [2:0] S_WR3  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;

  // 1 = current access belongs to MEM, 0 = IF
  logic        r_owner_mem;

  logic [19:0] r_sram_addr;
  logic [31:0] r_sram_wdata;
  logic        r_sram_drive;
  logic        r_sram_ce_n;
  logic        r_sram_oe_n;
  logic        r_sram_we_n;
  logic [3:0]  r_sram_be_n;

  logic        r_if_ready;
  logic        r_mem_ready;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;

  logic        w_grant_mem;
  logic        w_grant_if;
  logic        w_next_read;
  logic        w_next_write;
  logic        w_next_active;
  logic        w_unused;

  // MEM has priority; IF is granted only when MEM is not asking.
  assign w_grant_mem = (r_state == S_IDLE) && bus.mem_req;
  assign w_grant_if  = (r_state == S_IDLE) && !bus.mem_req && bus.if_req;

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_grant_mem)     w_next_state = bus.mem_we ? S_WR1 : S_RD1;
        else if (w_grant_if) w_next_state = S_RD1;
        else                 w_next_state = S_IDLE;
      end
      S_RD1:   w_next_state = S_RD2;
      S_RD2:   w_next_state = S_DONE;
      S_WR1:   w_next_state = S_WR2;
      S_WR2:   w_next_state = S_WR3;
      S_WR3:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_next_read   = (w_next_state == S_RD1) || (w_next_state == S_RD2);
  assign w_next_write  = (w_next_state == S_WR1) || (w_next_state == S_WR2) ||
                         (w_next_state == S_WR3);
  assign w_next_active = w_next_read || w_next_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_mem  <= 1'b0;
      r_sram_addr  <= 20'h0;
      r_sram_wdata <= 32'h0;
      r_sram_drive <= 1'b0;
      r_sram_ce_n  <= 1'b1;
      r_sram_oe_n  <= 1'b1;
      r_sram_we_n  <= 1'b1;
      r_sram_be_n  <= 4'hF;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_if_rdata   <= 32'h0;
      r_mem_rdata  <= 32'h0;
    end else begin
      r_state <= w_next_state;

      // Latch the winner's request so the requester may change or drop
      // its inputs for the rest of the access.
      if (w_grant_mem) begin
        r_owner_mem <= 1'b1;
        r_sram_addr <= bus.mem_addr[21:2];
        if (bus.mem_we) r_sram_wdata <= bus.mem_wdata;
      end else if (w_grant_if) begin
        r_owner_mem <= 1'b0;
        r_sram_addr <= bus.if_addr[21:2];
      end

      r_sram_ce_n  <= ~w_next_active;
      r_sram_oe_n  <= ~w_next_read;
      r_sram_we_n  <= ~(w_next_state == S_WR2);
      r_sram_drive <= w_next_write;

      // Byte lanes: IF fetches whole words; MEM uses its own enables, even
      // an all-zero set on a read (the cycle still runs).
      if (w_grant_mem)         r_sram_be_n <= ~bus.mem_be;
      else if (w_grant_if)     r_sram_be_n <= 4'h0;
      else if (!w_next_active) r_sram_be_n <= 4'hF;

      r_if_ready  <= (w_next_state == S_DONE) && !r_owner_mem;
      r_mem_ready <= (w_next_state == S_DONE) &&  r_owner_mem;

      // SRAM data has been stable for two cycles by the end of RD2.
      if (r_state == S_RD2) begin
        if (r_owner_mem) r_mem_rdata <= bus.sram_rdata;
        else             r_if_rdata  <= bus.sram_rdata;
      end
    end
  end

  assign bus.if_rdata   = r_if_rdata;
  assign bus.if_ready   = r_if_ready;
  assign bus.mem_rdata  = r_mem_rdata;
  assign bus.mem_ready  = r_mem_ready;
  assign bus.sram_addr  = r_sram_addr;
  assign bus.sram_wdata = r_sram_wdata;
  assign bus.sram_drive = r_sram_drive;
  assign bus.sram_ce_n  = r_sram_ce_n;
  assign bus.sram_oe_n  = r_sram_oe_n;
  assign bus.sram_we_n  = r_sram_we_n;
  assign bus.sram_be_n  = r_sram_be_n;
  assign bus.dbg_state  = r_state;

  // A stage stalls while it requests and has not yet seen its ready pulse.
  assign bus.stall_req = (bus.mem_req & ~r_mem_ready) | (bus.if_req & ~r_if_ready);

  // Byte-offset and above-SRAM address bits are intentionally dropped.
  assign w_unused = ^{bus.if_addr[31:22], bus.if_addr[1:0],
                      bus.mem_addr[31:22], bus.mem_addr[1:0]};

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed steps followed by randomized single-requester traffic. A small
//   SRAM device model answers the DUT pins; a separate reference memory is
//   updated from transaction semantics (byte-merged stores, whole-word reads)
//   and expected read data flows through exp_q.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic dev_init;

  always #5 clk = ~clk;

  ram_arbiter_if bus();

  ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- SRAM device model and reference memory ----------------
  logic [31:0] sram_dev [0:255];
  logic [31:0] ref_mem  [0:255];
  logic [31:0] exp_q[$];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_mem_rd;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B9) + 32'h1234_5678;
  endfunction

  assign bus.sram_rdata = (!bus.sram_ce_n && !bus.sram_oe_n) ?
                          sram_dev[bus.sram_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (dev_init) begin
      for (int i = 0; i < 256; i++) sram_dev[i] <= init_word(i);
    end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!bus.sram_be_n[b])
          sram_dev[bus.sram_addr[7:0]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic e_ce, input logic e_oe,
                             input logic e_we, input logic e_drv, input logic [3:0] e_be);
    chk(tag, "ce_n",  32'(bus.sram_ce_n),  32'(e_ce));
    chk(tag, "oe_n",  32'(bus.sram_oe_n),  32'(e_oe));
    chk(tag, "we_n",  32'(bus.sram_we_n),  32'(e_we));
    chk(tag, "drive", 32'(bus.sram_drive), 32'(e_drv));
    chk(tag, "be_n",  32'(bus.sram_be_n),  32'(e_be));
  endtask

  task automatic chk_rdata(input string tag);
    chk(tag, "if_rdata",  bus.if_rdata,  exp_if_rd);
    chk(tag, "mem_rdata", bus.mem_rdata, exp_mem_rd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.if_req   = 1'b0;
      bus.mem_req  = 1'b0;
      bus.if_addr  = $urandom;
      bus.mem_addr = $urandom;
      #1;
      chk_strobes(tag, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      chk(tag, "if_ready",  32'(bus.if_ready),  32'd0);
      chk(tag, "mem_ready", 32'(bus.mem_ready), 32'd0);
      chk(tag, "stall_req", 32'(bus.stall_req), 32'd0);
      chk_rdata(tag);
    end
  endtask

  // One access from a lone requester, starting with the DUT in IDLE.
  // Cycle 0 is the request cycle; ready is due in cycle 3 (read) / 4 (write).
  task automatic run_access(input bit is_mem, input bit we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit withdraw, input string tag);
    int         lat;
    bit         act;
    logic [7:0] idx;
    logic [3:0] e_be;
    logic       e_if_rdy;
    logic       e_mem_rdy;
    logic       e_stall;
    lat = we ? 4 : 3;
    idx = addr[9:2];
    if (!we) exp_q.push_back(ref_mem[idx]);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.mem_req = is_mem;
        bus.if_req  = !is_mem;
        if (is_mem) begin
          bus.mem_we    = we;
          bus.mem_be    = be;
          bus.mem_addr  = addr;
          bus.mem_wdata = wdata;
        end else begin
          bus.if_addr = addr;
        end
      end else begin
        // Requester inputs are free to change once granted.
        bus.if_addr   = $urandom;
        bus.mem_addr  = $urandom;
        bus.mem_wdata = $urandom;
        bus.mem_be    = 4'($urandom_range(0, 15));
        if (withdraw) begin
          bus.if_req  = 1'b0;
          bus.mem_req = 1'b0;
        end
      end
      #1;
      act       = (c >= 1) && (c < lat);
      e_be      = !act ? 4'hF : (is_mem ? ~be : 4'h0);
      e_if_rdy  = (c == lat) && !is_mem;
      e_mem_rdy = (c == lat) && is_mem;
      e_stall   = (bus.mem_req & ~e_mem_rdy) | (bus.if_req & ~e_if_rdy);
      chk_strobes(tag, !act, !(act && !we), !(we && c == 2), act && we, e_be);
      if (act) begin
        chk(tag, "sram_addr", 32'(bus.sram_addr), 32'(addr[21:2]));
        if (we) chk(tag, "sram_wdata", bus.sram_wdata, wdata);
      end
      chk(tag, "if_ready",  32'(bus.if_ready),  32'(e_if_rdy));
      chk(tag, "mem_ready", 32'(bus.mem_ready), 32'(e_mem_rdy));
      chk(tag, "stall_req", 32'(bus.stall_req), 32'(e_stall));
      if (c == lat) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else if (is_mem) begin
          exp_mem_rd = exp_q.pop_front();
        end else begin
          exp_if_rd = exp_q.pop_front();
        end
      end
      chk_rdata(tag);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          kind;
    int          gap;
    logic [31:0] a_mem;
    logic [31:0] a_if;
    logic [31:0] e_mem_word;
    logic [31:0] e_if_word;
    logic        m_act;
    logic        i_act;

    rst           = 1'b1;
    dev_init      = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    exp_if_rd     = 32'h0;
    exp_mem_rd    = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    dev_init = 1'b0;
    #1;

    // Reset state
    chk_strobes("reset", 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
    chk("reset", "if_ready",   32'(bus.if_ready),   32'd0);
    chk("reset", "mem_ready",  32'(bus.mem_ready),  32'd0);
    chk("reset", "sram_addr",  32'(bus.sram_addr),  32'd0);
    chk("reset", "sram_wdata", bus.sram_wdata,      32'd0);
    chk("reset", "stall_req",  32'(bus.stall_req),  32'd0);
    chk_rdata("reset");

    // IF read of 0x10 -> word 4 = DEADBEEF
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b1, "if_read");
    chk("if_read", "if_rdata_const", bus.if_rdata, 32'hDEAD_BEEF);

    // MEM byte store, then read it back to confirm the byte merge
    run_access(1'b1, 1'b1, 4'b0010, 32'h0000_0104, 32'h0000_AB00, 1'b0, "byte_store");
    idle(1, "post_store");
    run_access(1'b1, 1'b0, 4'b1111, 32'h0000_0104, 32'h0, 1'b1, "store_readback");

    // MEM read with no byte enables still runs the cycle
    run_access(1'b1, 1'b0, 4'b0000, 32'h0000_0208, 32'h0, 1'b1, "be0_read");

    // Held IF request: regrant only from the IDLE after DONE
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0, "held_1");
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0, "held_2");
    idle(2, "post_held");

    // Contention: MEM read and IF read in the same cycle
    a_mem      = 32'h0000_0330;
    a_if       = 32'h0000_0044;
    e_mem_word = ref_mem[a_mem[9:2]];
    e_if_word  = ref_mem[a_if[9:2]];
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_be   = 4'b0101;
        bus.mem_addr = a_mem;
        bus.if_req   = 1'b1;
        bus.if_addr  = a_if;
      end
      if (c == 4) bus.mem_req = 1'b0;
      #1;
      m_act = (c == 1) || (c == 2);
      i_act = (c == 5) || (c == 6);
      chk_strobes("contend", !(m_act || i_act), !(m_act || i_act), 1'b1, 1'b0,
                  m_act ? 4'b1010 : (i_act ? 4'b0000 : 4'hF));
      if (m_act) chk("contend", "sram_addr_mem", 32'(bus.sram_addr), 32'(a_mem[21:2]));
      if (i_act) chk("contend", "sram_addr_if",  32'(bus.sram_addr), 32'(a_if[21:2]));
      chk("contend", "mem_ready", 32'(bus.mem_ready), 32'(c == 3));
      chk("contend", "if_ready",  32'(bus.if_ready),  32'(c == 7));
      chk("contend", "stall_req", 32'(bus.stall_req), 32'(c <= 6));
      if (c == 3) exp_mem_rd = e_mem_word;
      if (c == 7) exp_if_rd  = e_if_word;
      chk_rdata("contend");
    end
    idle(1, "post_contend");

    // Reset during WR2 (all byte enables off so the SRAM content is unchanged)
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = 32'h0000_0500;
    bus.mem_wdata = 32'h1357_9BDF;
    @(negedge clk);
    #1;
    chk_strobes("rst_wr1", 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_strobes("rst_wr2", 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
    @(negedge clk);
    rst        = 1'b0;
    exp_if_rd  = 32'h0;
    exp_mem_rd = 32'h0;
    #1;
    chk_strobes("rst_after", 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
    chk("rst_after", "mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_after", "stall_req", 32'(bus.stall_req), 32'd1);
    chk_rdata("rst_after");
    // mem_req was still high in that IDLE cycle, so a fresh write starts
    // and completes even though the request is withdrawn now.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.mem_req = 1'b0;
      #1;
      chk_strobes("rst_regrant", c == 4, 1'b1, c != 2, c != 4, 4'hF);
      chk("rst_regrant", "mem_ready", 32'(bus.mem_ready), 32'(c == 4));
      chk("rst_regrant", "stall_req", 32'(bus.stall_req), 32'd0);
      chk_rdata("rst_regrant");
    end

    // Idle for 10 cycles
    idle(10, "idle");

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      run_access(kind != 0, kind == 2, 4'($urandom_range(0, 15)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), "rand");
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap, "rand_gap");
    end
    idle(1, "end");
    chk("end", "exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
